// File: rtl/vga_timing_gen_if.sv
// Pixel-side and pin-side signal bundle for vga_timing_gen.
// pix_req/pix_data is a fixed-latency request: no back-pressure, pix_data must be valid exactly PIX_LAT cycles after pix_req.
interface vga_timing_gen_if #(
    parameter int RGB_W = 16
);
    logic             en;
    logic [RGB_W-1:0] pix_data;
    logic             pix_req;
    logic [9:0]       pix_x;
    logic [9:0]       pix_y;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [RGB_W-1:0] rgb;
    logic             frame_start;
    logic             line_start;
    logic             dbg_state;

    modport master (
        input  en, pix_data,
        output pix_req, pix_x, pix_y, hsync, vsync, de, rgb,
               frame_start, line_start, dbg_state
    );

    modport slave (
        output en, pix_data,
        input  pix_req, pix_x, pix_y, hsync, vsync, de, rgb,
               frame_start, line_start, dbg_state
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with early pixel requests for a pipelined source.
// Line/frame order is sync, back porch, active, front porch; run/stop is only honoured at frame boundaries.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_LAT  = 1,
    parameter int RGB_W    = 16
) (
    input logic              vga_clk,
    input logic              sys_rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HC_W    = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VC_W    = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
    localparam int HA0     = H_SYNC + H_BACK;
    localparam int VA0     = V_SYNC + V_BACK;

    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] HA_LO      = HC_W'(HA0);
    localparam logic [HC_W-1:0] HA_HI      = HC_W'(HA0 + H_ACTIVE);
    localparam logic [HC_W-1:0] HR_LO      = HC_W'(HA0 - PIX_LAT);
    localparam logic [HC_W-1:0] HR_HI      = HC_W'(HA0 + H_ACTIVE - PIX_LAT);
    localparam logic [HC_W-1:0] H_LAT      = HC_W'(PIX_LAT);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] VA_LO      = VC_W'(VA0);
    localparam logic [VC_W-1:0] VA_HI      = VC_W'(VA0 + V_ACTIVE);
    localparam logic            HS_ON      = (HS_POL != 0);
    localparam logic            VS_ON      = (VS_POL != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HC_W-1:0]  r_h_cnt;
    logic [VC_W-1:0]  r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_frame_last;
    logic             w_run;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_v_act;
    logic             w_active;
    logic             w_req;
    logic             w_line_st;
    logic             w_frame_st;
    logic [HC_W-1:0]  w_h_off;
    logic [VC_W-1:0]  w_v_off;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;
    logic             r_frame_start;
    logic             r_line_start;

    assign w_h_last     = (r_h_cnt == H_LAST);
    assign w_v_last     = (r_v_cnt == V_LAST);
    assign w_frame_last = w_h_last && w_v_last;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.en) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_frame_last && !bus.en) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_hs_act   = w_run && (r_h_cnt < H_SYNC_END);
        w_vs_act   = w_run && (r_v_cnt < V_SYNC_END);
        w_v_act    = (r_v_cnt >= VA_LO) && (r_v_cnt < VA_HI);
        w_active   = w_run && w_v_act && (r_h_cnt >= HA_LO) && (r_h_cnt < HA_HI);
        // Request window is the active window shifted left by the source latency.
        w_req      = w_run && w_v_act && (r_h_cnt >= HR_LO) && (r_h_cnt < HR_HI);
        w_line_st  = w_run && (r_h_cnt == '0);
        w_frame_st = w_line_st && (r_v_cnt == '0);
    end

    // Counters sit at (0,0) while idle, so the first RUN cycle is the frame origin.
    always_ff @(posedge vga_clk) begin
        if (sys_rst || !w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HC_W'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_de          <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_hsync       <= w_hs_act ? HS_ON : ~HS_ON;
            r_vsync       <= w_vs_act ? VS_ON : ~VS_ON;
            r_de          <= w_active;
            r_rgb         <= w_active ? bus.pix_data : '0;
            r_frame_start <= w_frame_st;
            r_line_start  <= w_line_st;
        end
    end

    assign w_h_off = r_h_cnt + H_LAT - HA_LO;
    assign w_v_off = r_v_cnt - VA_LO;

    assign bus.pix_req     = w_req;
    assign bus.pix_x       = w_req ? w_h_off[9:0] : 10'd0;
    assign bus.pix_y       = w_req ? w_v_off[9:0] : 10'd0;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.rgb         = r_rgb;
    assign bus.frame_start = r_frame_start;
    assign bus.line_start  = r_line_start;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: two small-raster instances (latency 0 and latency 3) against hand-computed cycle vectors.
module tb_vga_timing_gen;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    vga_timing_gen_if #(.RGB_W(16)) bus_s();
    vga_timing_gen_if #(.RGB_W(16)) bus_p();

    // 10 clk/line, 6 lines/frame; active h 4..7, v 2..4
    vga_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
        .HS_POL(0), .VS_POL(0), .PIX_LAT(0), .RGB_W(16)
    ) dut_s (
        .vga_clk(clk), .sys_rst(rst), .bus(bus_s)
    );

    // 17 clk/line, 9 lines/frame; active h 7..14, v 4..7; requests h 4..11
    vga_timing_gen #(
        .H_SYNC(3), .H_BACK(4), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
        .HS_POL(0), .VS_POL(0), .PIX_LAT(3), .RGB_W(16)
    ) dut_p (
        .vga_clk(clk), .sys_rst(rst), .bus(bus_p)
    );

    // Pixel sources return {y[5:0],x[9:0]}; unrequested slots carry junk so rgb blanking is visible.
    logic [15:0] p_s1, p_s2, p_s3;
    assign bus_s.pix_data = bus_s.pix_req ? {bus_s.pix_y[5:0], bus_s.pix_x} : 16'hDEAD;
    always @(posedge clk) begin
        p_s1 <= bus_p.pix_req ? {bus_p.pix_y[5:0], bus_p.pix_x} : 16'hBEEF;
        p_s2 <= p_s1;
        p_s3 <= p_s2;
    end
    assign bus_p.pix_data = p_s3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " hsync_s"}, 32'(bus_s.hsync), 32'd1);
        check({tag, " vsync_s"}, 32'(bus_s.vsync), 32'd1);
        check({tag, " de_s"}, 32'(bus_s.de), 32'd0);
        check({tag, " rgb_s"}, 32'(bus_s.rgb), 32'd0);
        check({tag, " req_s"}, 32'(bus_s.pix_req), 32'd0);
        check({tag, " state_s"}, 32'(bus_s.dbg_state), 32'd0);
        check({tag, " hsync_p"}, 32'(bus_p.hsync), 32'd1);
        check({tag, " vsync_p"}, 32'(bus_p.vsync), 32'd1);
        check({tag, " de_p"}, 32'(bus_p.de), 32'd0);
        check({tag, " rgb_p"}, 32'(bus_p.rgb), 32'd0);
        check({tag, " fs_p"}, 32'(bus_p.frame_start), 32'd0);
        check({tag, " state_p"}, 32'(bus_p.dbg_state), 32'd0);
    endtask

    int de_s_cnt, de_p_cnt, ls_s_cnt, hs_s_low, vs_s_low, fs_late_s, fs_late_p;

    initial begin
        total = 0; bad = 0;
        de_s_cnt = 0; de_p_cnt = 0; ls_s_cnt = 0; hs_s_low = 0; vs_s_low = 0;
        fs_late_s = 0; fs_late_p = 0;
        rst = 1'b1; bus_s.en = 1'b0; bus_p.en = 1'b0;
        repeat (3) tick();
        check_idle("reset");

        rst = 1'b0; bus_s.en = 1'b1; bus_p.en = 1'b1;
        // At loop step n, combinational outputs show counter index n, registered ones index n-1.
        for (int n = 0; n <= 320; n++) begin
            tick();
            if (n >= 1 && n <= 60) begin
                de_s_cnt += int'(bus_s.de);
                ls_s_cnt += int'(bus_s.line_start);
                hs_s_low += int'(!bus_s.hsync);
                vs_s_low += int'(!bus_s.vsync);
            end
            if (n >= 1 && n <= 153) de_p_cnt += int'(bus_p.de);
            if (n >= 170) fs_late_s += int'(bus_s.frame_start);
            if (n >= 300) fs_late_p += int'(bus_p.frame_start);
            case (n)
                0: begin
                    check("n0 fs_s", 32'(bus_s.frame_start), 32'd0);
                    check("n0 hsync_s", 32'(bus_s.hsync), 32'd1);
                    check("n0 state_s", 32'(bus_s.dbg_state), 32'd1);
                end
                1: begin
                    check("n1 fs_s", 32'(bus_s.frame_start), 32'd1);
                    check("n1 ls_s", 32'(bus_s.line_start), 32'd1);
                    check("n1 hsync_s", 32'(bus_s.hsync), 32'd0);
                    check("n1 vsync_s", 32'(bus_s.vsync), 32'd0);
                    check("n1 fs_p", 32'(bus_p.frame_start), 32'd1);
                    check("n1 hsync_p", 32'(bus_p.hsync), 32'd0);
                end
                2: check("n2 fs_s", 32'(bus_s.frame_start), 32'd0);
                3: check("n3 hsync_s", 32'(bus_s.hsync), 32'd1);
                10: check("n10 vsync_s", 32'(bus_s.vsync), 32'd0);
                11: begin
                    check("n11 vsync_s", 32'(bus_s.vsync), 32'd1);
                    check("n11 ls_s", 32'(bus_s.line_start), 32'd1);
                end
                24: begin
                    check("n24 req_s", 32'(bus_s.pix_req), 32'd1);
                    check("n24 x_s", 32'(bus_s.pix_x), 32'd0);
                    check("n24 y_s", 32'(bus_s.pix_y), 32'd0);
                    check("n24 de_s", 32'(bus_s.de), 32'd0);
                end
                25: begin
                    check("n25 de_s", 32'(bus_s.de), 32'd1);
                    check("n25 rgb_s", 32'(bus_s.rgb), 32'h0000);
                end
                27: check("n27 x_s", 32'(bus_s.pix_x), 32'd3);
                28: begin
                    check("n28 req_s", 32'(bus_s.pix_req), 32'd0);
                    check("n28 x_s", 32'(bus_s.pix_x), 32'd0);
                    check("n28 rgb_s", 32'(bus_s.rgb), 32'h0003);
                end
                29: begin
                    check("n29 de_s", 32'(bus_s.de), 32'd0);
                    check("n29 rgb_s", 32'(bus_s.rgb), 32'd0);
                end
                36: begin
                    check("n36 rgb_s", 32'(bus_s.rgb), 32'h0401);
                    check("n36 x_s", 32'(bus_s.pix_x), 32'd2);
                    check("n36 y_s", 32'(bus_s.pix_y), 32'd1);
                end
                48: check("n48 rgb_s", 32'(bus_s.rgb), 32'h0803);
                49: check("n49 de_s", 32'(bus_s.de), 32'd0);
                60: check("n60 fs_s", 32'(bus_s.frame_start), 32'd0);
                61: check("n61 fs_s", 32'(bus_s.frame_start), 32'd1);
                71: check("n71 req_p", 32'(bus_p.pix_req), 32'd0);
                72: begin
                    check("n72 req_p", 32'(bus_p.pix_req), 32'd1);
                    check("n72 x_p", 32'(bus_p.pix_x), 32'd0);
                    check("n72 y_p", 32'(bus_p.pix_y), 32'd0);
                end
                75: check("n75 de_p", 32'(bus_p.de), 32'd0);
                76: begin
                    check("n76 de_p", 32'(bus_p.de), 32'd1);
                    check("n76 rgb_p", 32'(bus_p.rgb), 32'h0000);
                end
                79: check("n79 x_p", 32'(bus_p.pix_x), 32'd7);
                80: check("n80 req_p", 32'(bus_p.pix_req), 32'd0);
                83: check("n83 rgb_p", 32'(bus_p.rgb), 32'h0007);
                84: begin
                    check("n84 de_p", 32'(bus_p.de), 32'd0);
                    check("n84 rgb_p", 32'(bus_p.rgb), 32'd0);
                end
                100: check("n100 rgb_p", 32'(bus_p.rgb), 32'h0407);
                154: check("n154 fs_p", 32'(bus_p.frame_start), 32'd1);
                170: check("n170 state_s", 32'(bus_s.dbg_state), 32'd1);
                179: check("n179 state_s", 32'(bus_s.dbg_state), 32'd1);
                180: check("n180 state_s", 32'(bus_s.dbg_state), 32'd0);
                181: begin
                    check("n181 hsync_s", 32'(bus_s.hsync), 32'd1);
                    check("n181 vsync_s", 32'(bus_s.vsync), 32'd1);
                    check("n181 de_s", 32'(bus_s.de), 32'd0);
                    check("n181 ls_s", 32'(bus_s.line_start), 32'd0);
                end
                305: check("n305 state_p", 32'(bus_p.dbg_state), 32'd1);
                306: check("n306 state_p", 32'(bus_p.dbg_state), 32'd0);
                default: ;
            endcase
            if (n == 160) begin
                bus_s.en = 1'b0;
                bus_p.en = 1'b0;
            end
        end
        check("de_s per frame", 32'(de_s_cnt), 32'd12);
        check("de_p per frame", 32'(de_p_cnt), 32'd32);
        check("ls_s per frame", 32'(ls_s_cnt), 32'd6);
        check("hsync_s low per frame", 32'(hs_s_low), 32'd12);
        check("vsync_s low per frame", 32'(vs_s_low), 32'd10);
        check("fs_s after stop", 32'(fs_late_s), 32'd0);
        check("fs_p after stop", 32'(fs_late_p), 32'd0);

        // Restart, then reset in the middle of an active line.
        bus_s.en = 1'b1; bus_p.en = 1'b1;
        for (int m = 0; m <= 52; m++) begin
            tick();
            case (m)
                45: begin
                    check("m45 de_s", 32'(bus_s.de), 32'd1);
                    check("m45 rgb_s", 32'(bus_s.rgb), 32'h0800);
                end
                46: check_idle("m46");
                49: begin
                    check("m49 fs_s", 32'(bus_s.frame_start), 32'd0);
                    check("m49 fs_p", 32'(bus_p.frame_start), 32'd0);
                end
                50: begin
                    check("m50 fs_s", 32'(bus_s.frame_start), 32'd1);
                    check("m50 ls_s", 32'(bus_s.line_start), 32'd1);
                    check("m50 hsync_s", 32'(bus_s.hsync), 32'd0);
                    check("m50 fs_p", 32'(bus_p.frame_start), 32'd1);
                end
                default: ;
            endcase
            if (m == 45) rst = 1'b1;
            if (m == 48) rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
